// File: rtl/window_fetch.sv
// window_fetch: front-end fetch stage of the sharpening pipeline.
// Walks the frame in raster order, reads each pixel's 3x3 neighbourhood from
// image memory and presents the nine taps plus the output address for one
// cycle (win_valid). Stepping within a row reuses two columns (3 reads);
// each row start refills the whole window (9 reads).
// Optional build macro: ZERO_PAD_EN -- out-of-frame taps read as 0 with the
// memory strobe suppressed for that slot; otherwise tap coordinates clamp to
// the frame edge.
// Handshake: there is no back-pressure. mem_data is taken as valid exactly one
// cycle after mem_rd, and win_valid is a single-cycle strobe the downstream
// register must capture; vn*/oan stay stable until the next strobe.
module window_fetch #(
    parameter int IMG_W = 800,
    parameter int IMG_H = 600,
    parameter int AW    = 19,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          mem_rd,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_data,
    output logic [DW-1:0] vn0,
    output logic [DW-1:0] vn1,
    output logic [DW-1:0] vn2,
    output logic [DW-1:0] vn3,
    output logic [DW-1:0] vn4,
    output logic [DW-1:0] vn5,
    output logic [DW-1:0] vn6,
    output logic [DW-1:0] vn7,
    output logic [DW-1:0] vn8,
    output logic [AW-1:0] oan,
    output logic          win_valid,
    output logic          busy,
    output logic          done,
    output logic [2:0]    dbg_state
);

    localparam int XW = $clog2(IMG_W + 1);
    localparam int YW = $clog2(IMG_H + 1);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_SLIDE = 3'd2,
        S_EMIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t        state, state_n;
    logic [3:0]    cnt, cnt_n;
    logic [XW-1:0] x, x_n;
    logic [YW-1:0] y, y_n;

    logic [DW-1:0] win  [0:8];
    logic [DW-1:0] vn_q [0:8];

    logic [3:0]    rd_tap;
    logic [3:0]    cap_idx;
    logic [3:0]    cap_tap;
    logic          rd_slot;
    logic          cap_active;
    logic          cap_last;
    logic          rd_pad;
    logic          cap_pad;
    logic [DW-1:0] cap_val;

    // Clamped memory address of tap t (0..8, row-major) of the window at (cx,cy).
    // The row*IMG_W product is formed at AW bits so the last pixel does not wrap.
    function automatic logic [AW-1:0] tap_addr(input logic [3:0] t,
                                               input logic [XW-1:0] cx,
                                               input logic [YW-1:0] cy);
        int col;
        int row;
        col = int'(cx) + int'(t) % 3 - 1;
        row = int'(cy) + int'(t) / 3 - 1;
        if (col < 0) col = 0;
        if (col > IMG_W - 1) col = IMG_W - 1;
        if (row < 0) row = 0;
        if (row > IMG_H - 1) row = IMG_H - 1;
        return AW'(row) * AW'(IMG_W) + AW'(col);
    endfunction

`ifdef ZERO_PAD_EN
    // True when tap t of the window at (cx,cy) lies outside the frame.
    function automatic logic tap_oob(input logic [3:0] t,
                                     input logic [XW-1:0] cx,
                                     input logic [YW-1:0] cy);
        int col;
        int row;
        col = int'(cx) + int'(t) % 3 - 1;
        row = int'(cy) + int'(t) / 3 - 1;
        return (col < 0) || (col >= IMG_W) || (row < 0) || (row >= IMG_H);
    endfunction

    assign rd_pad  = tap_oob(rd_tap, x, y);
    assign cap_pad = tap_oob(cap_tap, x, y);
`else
    assign rd_pad  = 1'b0;
    assign cap_pad = 1'b0;
`endif

    // FILL reads taps 0..8 in slots 0..8; SLIDE reads the new right column
    // (taps 2,5,8) in slots 0..2. Each capture lands one slot after its read.
    assign rd_tap     = (state == S_SLIDE) ? 4'(cnt * 3 + 2) : cnt;
    assign cap_idx    = cnt - 4'd1;
    assign cap_tap    = (state == S_SLIDE) ? 4'(cap_idx * 3 + 2) : cap_idx;
    assign rd_slot    = ((state == S_FILL) && (cnt <= 4'd8)) ||
                        ((state == S_SLIDE) && (cnt <= 4'd2));
    assign cap_active = ((state == S_FILL) || (state == S_SLIDE)) && (cnt != 4'd0);
    assign cap_last   = ((state == S_FILL) && (cnt == 4'd9)) ||
                        ((state == S_SLIDE) && (cnt == 4'd3));
    assign cap_val    = cap_pad ? '0 : mem_data;

    assign mem_rd    = rd_slot && !rd_pad;
    assign mem_addr  = mem_rd ? tap_addr(rd_tap, x, y) : '0;
    assign win_valid = (state == S_EMIT);
    assign busy      = (state == S_FILL) || (state == S_SLIDE) || (state == S_EMIT);
    assign done      = (state == S_DONE);
    assign dbg_state = state;

    assign vn0 = vn_q[0];
    assign vn1 = vn_q[1];
    assign vn2 = vn_q[2];
    assign vn3 = vn_q[3];
    assign vn4 = vn_q[4];
    assign vn5 = vn_q[5];
    assign vn6 = vn_q[6];
    assign vn7 = vn_q[7];
    assign vn8 = vn_q[8];

    // Next-state, slot counter and raster position.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        x_n     = x;
        y_n     = y;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_n = S_FILL;
                    cnt_n   = 4'd0;
                    x_n     = '0;
                    y_n     = '0;
                end
            end
            S_FILL: begin
                if (cnt == 4'd9) begin
                    state_n = S_EMIT;
                    cnt_n   = 4'd0;
                end else begin
                    cnt_n = cnt + 4'd1;
                end
            end
            S_SLIDE: begin
                if (cnt == 4'd3) begin
                    state_n = S_EMIT;
                    cnt_n   = 4'd0;
                end else begin
                    cnt_n = cnt + 4'd1;
                end
            end
            S_EMIT: begin
                cnt_n = 4'd0;
                if (x != X_LAST) begin
                    x_n     = x + 1'b1;
                    state_n = S_SLIDE;
                end else if (y != Y_LAST) begin
                    x_n     = '0;
                    y_n     = y + 1'b1;
                    state_n = S_FILL;
                end else begin
                    state_n = S_DONE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // State register; reset always wins over start.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
            x     <= '0;
            y     <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            x     <= x_n;
            y     <= y_n;
        end
    end

    // Working window (shift on step, capture per slot) and the held outputs,
    // which are refreshed only when the final tap of a window arrives.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 9; i++) begin
                win[i]  <= '0;
                vn_q[i] <= '0;
            end
            oan <= '0;
        end else if ((state == S_EMIT) && (state_n == S_SLIDE)) begin
            win[0] <= win[1];
            win[1] <= win[2];
            win[3] <= win[4];
            win[4] <= win[5];
            win[6] <= win[7];
            win[7] <= win[8];
        end else if (cap_active) begin
            win[cap_tap] <= cap_val;
            if (cap_last) begin
                for (int i = 0; i < 9; i++) begin
                    vn_q[i] <= (4'(i) == cap_tap) ? cap_val : win[i];
                end
                oan <= AW'(y) * AW'(IMG_W) + AW'(x);
            end
        end
    end

endmodule

// File: tb/tb_window_fetch.sv
// Testbench for window_fetch: a full-size instance (800x600) for the first
// windows of a frame and a reduced 4x3 instance for whole-frame runs.
// Memory returns mem[a] = a[7:0] one cycle after a read; otherwise random data.
module tb_window_fetch;

    localparam int AW = 19;
    localparam int DW = 8;
    localparam int SW = 4;
    localparam int SH = 3;

    logic clk = 1'b0;
    logic reset;
    logic start_b, start_s;

    logic          b_rd, s_rd;
    logic [AW-1:0] b_addr, s_addr;
    logic [DW-1:0] b_data, s_data;
    logic [DW-1:0] b_v [0:8];
    logic [DW-1:0] s_v [0:8];
    logic [AW-1:0] b_oan, s_oan;
    logic          b_valid, s_valid, b_busy, s_busy, b_done, s_done;
    logic [2:0]    b_state, s_state;
    logic [71:0]   b_win, s_win;

    assign b_win = {b_v[0], b_v[1], b_v[2], b_v[3], b_v[4], b_v[5], b_v[6], b_v[7], b_v[8]};
    assign s_win = {s_v[0], s_v[1], s_v[2], s_v[3], s_v[4], s_v[5], s_v[6], s_v[7], s_v[8]};

    int n_total = 0;
    int n_pass  = 0;

    // Collected observation of one window.
    int          got_lat;
    int          got_n;
    logic [31:0] got_rd [16];
    logic [71:0] got_win;
    logic [AW-1:0] got_oan;

    // Reference expectations for one window.
    logic [31:0]   exp_q[$];
    logic [71:0]   exp_win;
    logic [AW-1:0] exp_oan;
    int            exp_lat;

    window_fetch dut (
        .clk(clk), .reset(reset), .start(start_b),
        .mem_rd(b_rd), .mem_addr(b_addr), .mem_data(b_data),
        .vn0(b_v[0]), .vn1(b_v[1]), .vn2(b_v[2]), .vn3(b_v[3]), .vn4(b_v[4]),
        .vn5(b_v[5]), .vn6(b_v[6]), .vn7(b_v[7]), .vn8(b_v[8]),
        .oan(b_oan), .win_valid(b_valid), .busy(b_busy), .done(b_done),
        .dbg_state(b_state)
    );

    window_fetch #(.IMG_W(SW), .IMG_H(SH), .AW(AW), .DW(DW)) dut_s (
        .clk(clk), .reset(reset), .start(start_s),
        .mem_rd(s_rd), .mem_addr(s_addr), .mem_data(s_data),
        .vn0(s_v[0]), .vn1(s_v[1]), .vn2(s_v[2]), .vn3(s_v[3]), .vn4(s_v[4]),
        .vn5(s_v[5]), .vn6(s_v[6]), .vn7(s_v[7]), .vn8(s_v[8]),
        .oan(s_oan), .win_valid(s_valid), .busy(s_busy), .done(s_done),
        .dbg_state(s_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Image memories: one-cycle read latency, garbage when not read.
    always @(posedge clk) begin
        b_data <= b_rd ? b_addr[7:0] : 8'($urandom);
        s_data <= s_rd ? s_addr[7:0] : 8'($urandom);
    end

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Reference model: expected taps, reads (slot<<20 | address), latency and
    // output address for the window centred on (x,y) of a w x h frame.
    task automatic model_window(input int x, input int y, input int w, input int h, input bit fill);
        int  c, r, a;
        bit  pad [9];
        int  addr [9];
        exp_q.delete();
        exp_win = '0;
        exp_lat = fill ? 10 : 4;
        exp_oan = AW'(y * w + x);
        for (int t = 0; t < 9; t++) begin
            c = x + t % 3 - 1;
            r = y + t / 3 - 1;
            pad[t] = 1'b0;
`ifdef ZERO_PAD_EN
            pad[t] = (c < 0) || (c >= w) || (r < 0) || (r >= h);
`endif
            c = (c < 0) ? 0 : ((c > w - 1) ? w - 1 : c);
            r = (r < 0) ? 0 : ((r > h - 1) ? h - 1 : r);
            a = r * w + c;
            addr[t] = a;
            exp_win[(8 - t) * 8 +: 8] = pad[t] ? 8'd0 : 8'(a % 256);
        end
        if (fill) begin
            for (int t = 0; t < 9; t++)
                if (!pad[t]) exp_q.push_back((32'(t) << 20) | 32'(addr[t]));
        end else begin
            for (int k = 0; k < 3; k++)
                if (!pad[3 * k + 2]) exp_q.push_back((32'(k) << 20) | 32'(addr[3 * k + 2]));
        end
    endtask

    // Driver/monitor: steps cycle by cycle (sampling on negedge) until the
    // selected instance strobes win_valid, recording every read and its slot.
    task automatic collect(input bit sm);
        got_lat = -1;
        got_n   = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            start_b = 1'b0;
            start_s = 1'b0;
            if (sm ? s_rd : b_rd) begin
                if (got_n < 16) got_rd[got_n] = (32'(c) << 20) | 32'(sm ? s_addr : b_addr);
                got_n++;
            end
            if (sm ? s_valid : b_valid) begin
                got_lat = c;
                got_win = sm ? s_win : b_win;
                got_oan = sm ? s_oan : b_oan;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start_b = 1'b1; start_s = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0; start_b = 1'b0; start_s = 1'b0;
        n_total++; if (b_state !== 3'd0) $display("FAIL reset_state: got %0d want 0", b_state); else n_pass++;
        n_total++; if (b_rd !== 1'b0 || b_addr !== '0) $display("FAIL reset_mem: got rd=%0b addr=%0d want 0", b_rd, b_addr); else n_pass++;
        n_total++; if (b_win !== '0) $display("FAIL reset_taps: got %h want 0", b_win); else n_pass++;
        n_total++; if (b_oan !== '0) $display("FAIL reset_oan: got %0d want 0", b_oan); else n_pass++;
        n_total++; if ({b_valid, b_busy, b_done} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {b_valid, b_busy, b_done}); else n_pass++;
        n_total++; if ({s_state, s_rd, s_win, s_oan, s_valid, s_busy, s_done} !== '0) $display("FAIL reset_small: got nonzero outputs, state %0d", s_state); else n_pass++;
    endtask

    task automatic test_big_row;
        int nsteps;
        repeat ($urandom_range(0, 3)) @(negedge clk);
        nsteps = $urandom_range(2, 6);
        start_b = 1'b1;
        for (int x = 0; x <= nsteps; x++) begin
            collect(1'b0);
            model_window(x, 0, 800, 600, x == 0);
            n_total++; if (got_lat !== exp_lat) $display("FAIL big%0d latency: got %0d want %0d", x, got_lat, exp_lat); else n_pass++;
            n_total++; if (got_n !== exp_q.size()) $display("FAIL big%0d read_count: got %0d want %0d", x, got_n, exp_q.size()); else n_pass++;
            for (int i = 0; i < got_n && i < exp_q.size() && i < 16; i++) begin
                n_total++; if (got_rd[i] !== exp_q[i]) $display("FAIL big%0d read%0d: got slot/addr %h want %h", x, i, got_rd[i], exp_q[i]); else n_pass++;
            end
            n_total++; if (got_win !== exp_win) $display("FAIL big%0d taps: got %h want %h", x, got_win, exp_win); else n_pass++;
            n_total++; if (got_oan !== exp_oan) $display("FAIL big%0d oan: got %0d want %0d", x, got_oan, exp_oan); else n_pass++;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset_mid_fill;
        int seen;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_total++; if (b_rd !== 1'b0) $display("FAIL abort_rd: got %0b want 0", b_rd); else n_pass++;
        n_total++; if (b_busy !== 1'b0 || b_state !== 3'd0) $display("FAIL abort_state: got busy=%0b state=%0d want 0/0", b_busy, b_state); else n_pass++;
        reset = 1'b0;
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (b_valid) seen++;
        end
        n_total++; if (seen !== 0) $display("FAIL abort_no_window: got %0d strobes want 0", seen); else n_pass++;
        start_b = 1'b1;
        collect(1'b0);
        model_window(0, 0, 800, 600, 1'b1);
        n_total++; if (got_lat !== exp_lat) $display("FAIL restart latency: got %0d want %0d", got_lat, exp_lat); else n_pass++;
        n_total++; if (got_n !== exp_q.size()) $display("FAIL restart read_count: got %0d want %0d", got_n, exp_q.size()); else n_pass++;
        n_total++; if (got_win !== exp_win) $display("FAIL restart taps: got %h want %h", got_win, exp_win); else n_pass++;
        n_total++; if (got_oan !== exp_oan) $display("FAIL restart oan: got %0d want %0d", got_oan, exp_oan); else n_pass++;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_small_frame;
        int inj;
        for (int pass = 0; pass < 2; pass++) begin
            repeat ($urandom_range(0, 4)) @(negedge clk);
            inj = $urandom_range(1, SW * SH - 1);
            start_s = 1'b1;
            for (int i = 0; i < SW * SH; i++) begin
                if (pass == 0 && i == inj) start_s = 1'b1;
                collect(1'b1);
                model_window(i % SW, i / SW, SW, SH, (i % SW) == 0);
                n_total++; if (got_lat !== exp_lat) $display("FAIL small%0d_%0d latency: got %0d want %0d", pass, i, got_lat, exp_lat); else n_pass++;
                n_total++; if (got_n !== exp_q.size()) $display("FAIL small%0d_%0d read_count: got %0d want %0d", pass, i, got_n, exp_q.size()); else n_pass++;
                for (int k = 0; k < got_n && k < exp_q.size() && k < 16; k++) begin
                    n_total++; if (got_rd[k] !== exp_q[k]) $display("FAIL small%0d_%0d read%0d: got %h want %h", pass, i, k, got_rd[k], exp_q[k]); else n_pass++;
                end
                n_total++; if (got_win !== exp_win) $display("FAIL small%0d_%0d taps: got %h want %h", pass, i, got_win, exp_win); else n_pass++;
                n_total++; if (got_oan !== exp_oan) $display("FAIL small%0d_%0d oan: got %0d want %0d", pass, i, got_oan, exp_oan); else n_pass++;
                if (i == 0) begin
                    n_total++; if ({s_busy, s_done} !== 2'b10) $display("FAIL small%0d busy_flags: got %b want 10", pass, {s_busy, s_done}); else n_pass++;
                end
            end
            @(negedge clk);
            n_total++; if ({s_done, s_busy, s_valid, s_rd} !== 4'b1000) $display("FAIL small%0d done_flags: got %b want 1000", pass, {s_done, s_busy, s_valid, s_rd}); else n_pass++;
        end
    endtask

    initial begin
        reset = 1'b1; start_b = 1'b0; start_s = 1'b0;
        test_reset();
        test_big_row();
        test_reset_mid_fill();
        test_small_frame();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
